// File: rtl/usb_burst_demux.sv
// Receive-side burst demultiplexer: reads the interleaved USB FIFO stream and
// steers alternating BURST_LEN-word bursts to channel 1 and channel 2.
module usb_burst_demux #(
    parameter int DATA_W    = 16,
    parameter int BURST_LEN = 1023,
    parameter int CNT_W     = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rst_all_fifo,
    input  logic [DATA_W-1:0] usb_fifo_dout,
    input  logic              usb_fifo_empty,
    output logic              usb_fifo_rdreq,
    input  logic              chn1_full,
    input  logic              chn2_full,
    output logic [DATA_W-1:0] chn1_Datain,
    output logic              chn1_Datain_en,
    output logic [DATA_W-1:0] chn2_Datain,
    output logic              chn2_Datain_en,
    output logic              cur_chn,
    output logic              burst_done,
    output logic [15:0]       burst_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_SWITCH
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic              drain_cnt_q, drain_cnt_d;
    logic              cur_chn_q, cur_chn_d;
    logic [15:0]       burst_cnt_q, burst_cnt_d;
    logic              rd_vld_q, rd_vld_d;
    logic              rd_chn_q, rd_chn_d;
    logic [DATA_W-1:0] chn1_data_q, chn1_data_d;
    logic              chn1_en_q, chn1_en_d;
    logic [DATA_W-1:0] chn2_data_q, chn2_data_d;
    logic              chn2_en_q, chn2_en_d;
    logic              full_sel;

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of its _d regardless of process order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: default first, so no path through the block leaves state_d
        // unassigned and no latch is inferred.
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = S_READ;
            S_READ:   if (word_cnt_d == LAST_CNT) state_d = S_DRAIN;
            S_DRAIN:  if (drain_cnt_q) state_d = S_SWITCH;
            S_SWITCH: state_d = S_READ;
            default:  state_d = S_IDLE;
        endcase
        if (rst_all_fifo) begin
            state_d = S_IDLE;
        end
    end

    always_comb begin
        full_sel       = cur_chn_q ? chn2_full : chn1_full;
        usb_fifo_rdreq = (state_q == S_READ) && !usb_fifo_empty && !full_sel
                         && (word_cnt_q < LAST_CNT);
        burst_done     = (state_q == S_SWITCH);
    end

    // Channel select travels with the read so in-flight words keep their target.
    always_comb begin
        word_cnt_d = word_cnt_q;
        if ((state_q == S_IDLE) || (state_q == S_SWITCH)) begin
            word_cnt_d = '0;
        end else if (usb_fifo_rdreq) begin
            word_cnt_d = word_cnt_q + CNT_W'(1);
        end
        drain_cnt_d = (state_q == S_DRAIN) ? !drain_cnt_q : 1'b0;
        cur_chn_d   = cur_chn_q ^ (state_q == S_SWITCH);
        burst_cnt_d = (state_q == S_SWITCH) ? burst_cnt_q + 16'd1 : burst_cnt_q;
        rd_vld_d    = usb_fifo_rdreq;
        rd_chn_d    = cur_chn_q;
        chn1_en_d   = rd_vld_q && !rd_chn_q;
        chn2_en_d   = rd_vld_q && rd_chn_q;
        chn1_data_d = chn1_en_d ? usb_fifo_dout : chn1_data_q;
        chn2_data_d = chn2_en_d ? usb_fifo_dout : chn2_data_q;
        if (rst_all_fifo) begin
            word_cnt_d  = '0;
            drain_cnt_d = 1'b0;
            cur_chn_d   = 1'b0;
            burst_cnt_d = '0;
            rd_vld_d    = 1'b0;
            rd_chn_d    = 1'b0;
            chn1_en_d   = 1'b0;
            chn2_en_d   = 1'b0;
            chn1_data_d = '0;
            chn2_data_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_cnt_q  <= '0;
            drain_cnt_q <= 1'b0;
            cur_chn_q   <= 1'b0;
            burst_cnt_q <= '0;
            rd_vld_q    <= 1'b0;
            rd_chn_q    <= 1'b0;
            chn1_en_q   <= 1'b0;
            chn2_en_q   <= 1'b0;
            chn1_data_q <= '0;
            chn2_data_q <= '0;
        end else begin
            word_cnt_q  <= word_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            cur_chn_q   <= cur_chn_d;
            burst_cnt_q <= burst_cnt_d;
            rd_vld_q    <= rd_vld_d;
            rd_chn_q    <= rd_chn_d;
            chn1_en_q   <= chn1_en_d;
            chn2_en_q   <= chn2_en_d;
            chn1_data_q <= chn1_data_d;
            chn2_data_q <= chn2_data_d;
        end
    end

    assign chn1_Datain    = chn1_data_q;
    assign chn1_Datain_en = chn1_en_q;
    assign chn2_Datain    = chn2_data_q;
    assign chn2_Datain_en = chn2_en_q;
    assign cur_chn        = cur_chn_q;
    assign burst_cnt      = burst_cnt_q;

endmodule

// File: doc/usb_burst_demux.md
# usb_burst_demux

Receive-side counterpart of the two-channel burst packer. Reads the interleaved word stream from the external USB FIFO and steers each burst back to its channel: `BURST_LEN` words to channel 1, then `BURST_LEN` words to channel 2, alternating indefinitely. Each channel is written into its own downstream FIFO. The block is used on the loopback/readback path and in system benches to rebuild per-channel data from the card's output stream.

## Interface
Parameters:
- `DATA_W`, 16, word width.
- `BURST_LEN`, 1023, words per burst; legal range 2..1023.
- `CNT_W`, 10, width of the word counter; must satisfy 2^CNT_W > BURST_LEN.

Ports:
- `clk`  in  1  single clock for all logic.
- `reset`  in  1  asynchronous, active-high reset.
- `rst_all_fifo`  in  1  synchronous clear of all block state, same effect as reset.
- `usb_fifo_dout`  in  DATA_W  q of the external FIFO, standard (non-show-ahead) mode: valid 1 cycle after `rdreq`.
- `usb_fifo_empty`  in  1  external FIFO empty.
- `usb_fifo_rdreq`  out  1  read request to the external FIFO.
- `chn1_full`  in  1  channel-1 downstream FIFO almost-full; asserted with ≥2 free slots remaining.
- `chn2_full`  in  1  channel-2 downstream FIFO almost-full; same rule.
- `chn1_Datain`  out  DATA_W  channel-1 word.
- `chn1_Datain_en`  out  1  channel-1 write strobe.
- `chn2_Datain`  out  DATA_W  channel-2 word.
- `chn2_Datain_en`  out  1  channel-2 write strobe.
- `cur_chn`  out  1  currently selected channel; 0 = chn1, 1 = chn2.
- `burst_done`  out  1  one-cycle pulse when a burst has been fully delivered.
- `burst_cnt`  out  16  completed bursts, wraps 0xFFFF→0.

## Operation
- State machine with states IDLE, READ, DRAIN, SWITCH.
  - IDLE: clear the word counter, then go to READ on the next cycle.
  - READ: issue reads. When the issued-word count reaches `BURST_LEN`, go to DRAIN.
  - DRAIN: hold for exactly 2 cycles so in-flight words reach the outputs.
  - SWITCH: toggle `cur_chn`, pulse `burst_done`, increment `burst_cnt`, clear the word counter, return to READ.
- `usb_fifo_rdreq` is combinational: (state==READ) & ~`usb_fifo_empty` & ~full_sel & (word_cnt < `BURST_LEN`).
  - full_sel is `chn1_full` when `cur_chn`=0, else `chn2_full`.
  - It deasserts in the same cycle that empty or full_sel asserts.
- word_cnt increments on each cycle `rdreq`=1 and never exceeds `BURST_LEN`.
- The target channel is captured together with `rdreq` (pipelined select), so words in flight always go to the channel that requested them.
- Reads are never issued for the next channel before DRAIN completes.
- Only one `ChnX_Datain_en` is high in any cycle. The Datain bus of the non-strobed channel holds its last value.
- Stalls from empty or full in the middle of a burst pause the burst without losing its position: word_cnt is held, and reading resumes when the stall clears.
- `rst_all_fifo` or `reset`:
  - state = IDLE, `cur_chn` = 0, word_cnt = 0, `burst_cnt` = 0;
  - pipeline valids cleared, so any in-flight word is discarded.
  - With `rst_all_fifo` and reset both asserted, reset wins; the result is identical.

## Timing
- Reset values: `usb_fifo_rdreq`=0, `chn1_Datain`=0, `chn2_Datain`=0, `chn1_Datain_en`=0, `chn2_Datain_en`=0, `cur_chn`=0, `burst_done`=0, `burst_cnt`=0.
- First possible `rdreq` is 2 cycles after reset release (1 cycle in IDLE, then READ).
- Latency from `rdreq` (cycle N) to `ChnX_Datain_en` is 2 cycles.
  - q is sampled in cycle N+1.
  - The output register updates at the end of N+1, so the strobe and data are visible in N+2.
- Throughput: 1 word/cycle when unstalled.
- Burst period when unstalled is `BURST_LEN` + 3 cycles (READ `BURST_LEN` + DRAIN 2 + SWITCH 1).
- `burst_done` is high during the SWITCH cycle; `cur_chn` and `burst_cnt` take their new values in the following cycle.
- Almost-full margin: at most 2 words are in flight after full_sel asserts, so downstream must accept them.
- An asynchronous reset in the middle of a burst takes effect immediately on the outputs. A `rst_all_fifo` in the middle of a burst takes effect at the next edge; strobes are low from the cycle after it is sampled.

## Test plan
- Non-empty FIFO holding words 0..2045 ascending, no stalls → `chn1_Datain` receives 0..1022 and `chn2_Datain` receives 1023..2045.
  - `burst_done` pulses twice, 1026 cycles apart.
  - `burst_cnt`=2 and `cur_chn`=0 at the end.
- Empty asserted for 5 cycles after word 100 → `rdreq` drops in the same cycle. chn1 receives 0..1022 contiguous, with no duplicates and no gaps.
- `chn1_full` pulsed for 10 cycles in the middle of a burst → at most 2 strobes after assertion, then a pause. The burst still totals exactly 1023 chn1 words.
- `BURST_LEN`=4 with 12 words queued → chn1 gets w0-w3 and w8-w11, chn2 gets w4-w7, `burst_cnt`=3. `rdreq` never overlaps DRAIN.
- `rst_all_fifo` pulsed after 500 chn1 words → no further strobes for 2 cycles. The next word read from the FIFO goes to chn1 with word_cnt restarted, and `burst_cnt`=0.
- `reset` asserted in the middle of a chn2 burst → all outputs are 0 asynchronously. `cur_chn`=0, and after release the first strobe is on chn1.
